// File: rtl/axi_wr_burst_buffer.sv
// Write-side burst buffer: a FIFO that releases data downstream only in complete BURST_LEN-beat bursts.
// Optional feature: define AXI_WR_BURST_PAD_FLUSH_EN to zero-pad a short packet (s_tlast) out to a full burst.
module axi_wr_burst_buffer #(
    parameter int DATA_WIDTH = 64,
    parameter int BURST_LEN  = 16,
    parameter int DEPTH      = 64
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [DATA_WIDTH-1:0]    s_tdata,
    input  logic                     s_tvalid,
    input  logic                     s_tlast,
    output logic                     s_tready,
    output logic [DATA_WIDTH-1:0]    m_tdata,
    output logic                     m_tvalid,
    output logic                     m_tlast,
    input  logic                     m_tready,
    output logic [$clog2(DEPTH):0]   o_level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam int CW = $clog2(BURST_LEN);
    localparam logic [LW-1:0] LVL_FULL   = LW'(DEPTH);
    localparam logic [LW-1:0] LVL_BURST  = LW'(BURST_LEN);
    localparam logic [CW-1:0] CNT_LAST   = CW'(BURST_LEN - 1);
    localparam logic [CW-1:0] CNT_PENULT = CW'(BURST_LEN - 2);

    typedef enum logic {RD_IDLE, RD_SEND} rd_state_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wr_ptr;
    logic [AW-1:0]         rd_ptr;
    logic [LW-1:0]         level;
    logic [CW-1:0]         wr_pos;
    logic [CW-1:0]         beat_cnt;
    rd_state_t             rd_state;
    logic                  ready_en;
    logic                  wr_en;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] wr_data;

`ifdef AXI_WR_BURST_PAD_FLUSH_EN
    typedef enum logic {WR_FILL, WR_PAD} wr_state_t;

    wr_state_t wr_state;
    logic      pad_wr;

    assign pad_wr   = (wr_state == WR_PAD) && (level < LVL_FULL);
    assign s_tready = ready_en && (level < LVL_FULL) && (wr_state == WR_FILL);
    assign wr_en    = (s_tvalid && s_tready) || pad_wr;
    assign wr_data  = pad_wr ? '0 : s_tdata;

    // A short packet pads with zeros until the write position wraps, so the tail forms a full burst.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_state <= WR_FILL;
        end else if (wr_en) begin
            if (wr_state == WR_PAD) begin
                if (wr_pos == CNT_LAST) wr_state <= WR_FILL;
            end else if (s_tlast && (wr_pos != CNT_LAST)) begin
                wr_state <= WR_PAD;
            end
        end
    end
`else
    logic unused_tlast;

    assign unused_tlast = s_tlast;
    assign s_tready     = ready_en && (level < LVL_FULL);
    assign wr_en        = s_tvalid && s_tready;
    assign wr_data      = s_tdata;
`endif

    assign rd_en   = m_tvalid && m_tready;
    assign m_tdata = mem[rd_ptr];
    assign o_level = level;

    // Holds s_tready low throughout reset and releases it on the first edge afterwards.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) ready_en <= 1'b0;
        else          ready_en <= 1'b1;
    end

    // NOTE: storage is not reset; clearing the pointers and level is what discards the contents.
    always_ff @(posedge i_clk) begin
        if (wr_en) mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            wr_pos <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + AW'(1);
                wr_pos <= (wr_pos == CNT_LAST) ? '0 : wr_pos + CW'(1);
            end
            if (rd_en) rd_ptr <= rd_ptr + AW'(1);
            if (wr_en && !rd_en)      level <= level + LW'(1);
            else if (rd_en && !wr_en) level <= level - LW'(1);
        end
    end

    // Read FSM: a burst starts only once a full burst is stored, so it can never run dry part way.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rd_state <= RD_IDLE;
            beat_cnt <= '0;
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end else begin
            case (rd_state)
                RD_IDLE: begin
                    if (level >= LVL_BURST) begin
                        rd_state <= RD_SEND;
                        m_tvalid <= 1'b1;
                        m_tlast  <= 1'b0;
                    end
                end
                RD_SEND: begin
                    if (m_tready) begin
                        if (beat_cnt == CNT_LAST) begin
                            rd_state <= RD_IDLE;
                            beat_cnt <= '0;
                            m_tvalid <= 1'b0;
                            m_tlast  <= 1'b0;
                        end else begin
                            beat_cnt <= beat_cnt + CW'(1);
                            m_tlast  <= (beat_cnt == CNT_PENULT);
                        end
                    end
                end
                default: rd_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_wr_burst_buffer.sv
// Bench for axi_wr_burst_buffer: queue-based reference model checked every cycle, plus a vector table and corner sequences.
// Build with AXI_WR_BURST_PAD_FLUSH_EN defined to exercise the zero-pad flush.
module tb_axi_wr_burst_buffer;

    localparam int DW    = 64;
    localparam int BL    = 16;
    localparam int DEPTH = 64;

    logic          i_clk;
    logic          i_rst_n;
    logic [DW-1:0] s_tdata;
    logic          s_tvalid;
    logic          s_tlast;
    logic          s_tready;
    logic [DW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tlast;
    logic          m_tready;
    logic [$clog2(DEPTH):0] o_level;

    axi_wr_burst_buffer #(.DATA_WIDTH(DW), .BURST_LEN(BL), .DEPTH(DEPTH)) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .s_tdata  (s_tdata),
        .s_tvalid (s_tvalid),
        .s_tlast  (s_tlast),
        .s_tready (s_tready),
        .m_tdata  (m_tdata),
        .m_tvalid (m_tvalid),
        .m_tlast  (m_tlast),
        .m_tready (m_tready),
        .o_level  (o_level)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    int total = 0;
    int bad   = 0;

    // Reference model: stored data as a queue, plus burst progress and padding status.
    logic [DW-1:0] q[$];
    bit m_burst;
    int m_sent;
    int m_pos;
    bit m_pad;
    bit m_rdy_en;

    int rdy_mode;  // 0 stall, 1 always ready, 2 toggle, 3 random
    logic [DW-1:0] next_data;
    int acc_cnt, out_cnt, last_cnt, zero_cnt, low_cnt;

    typedef struct {
        int n_offer;
        int rdy_mode;
        int exp_acc;
        int exp_out;
        int exp_last;
        int exp_level;
    } vec_t;

    vec_t tbl [6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clr();
        acc_cnt = 0; out_cnt = 0; last_cnt = 0; zero_cnt = 0; low_cnt = 0;
        next_data = 64'd1;
    endtask

    // Called at a falling edge: compares DUT against the model, then advances both by one clock.
    task automatic step();
        bit exp_tready, exp_tvalid, exp_tlast, w, r;
        logic [DW-1:0] wd;
        int lvl;
        case (rdy_mode)
            0: m_tready = 1'b0;
            1: m_tready = 1'b1;
            2: m_tready = ~m_tready;
            default: m_tready = 1'($urandom_range(0, 1));
        endcase
        #1;
        exp_tready = m_rdy_en && (q.size() < DEPTH) && !m_pad;
        exp_tvalid = m_burst;
        exp_tlast  = m_burst && (m_sent == BL - 1);
        check("s_tready", s_tready, exp_tready);
        check("m_tvalid", m_tvalid, exp_tvalid);
        check("m_tlast", m_tlast, exp_tlast);
        check("o_level", o_level, q.size());
        if (exp_tvalid && q.size() > 0) check("m_tdata", m_tdata, q[0]);
        if (!s_tready) low_cnt++;
        if (s_tvalid && s_tready) acc_cnt++;
        if (m_tvalid && m_tready) begin
            out_cnt++;
            if (m_tlast) last_cnt++;
            if (m_tdata == '0) zero_cnt++;
        end
        w   = (s_tvalid && exp_tready) || (m_pad && q.size() < DEPTH);
        wd  = m_pad ? '0 : s_tdata;
        r   = exp_tvalid && m_tready;
        lvl = q.size();
        @(posedge i_clk);
        if (r) begin
            void'(q.pop_front());
            m_sent++;
            if (m_sent == BL) begin
                m_burst = 0;
                m_sent  = 0;
            end
        end else if (!m_burst && lvl >= BL) begin
            m_burst = 1;
        end
        if (w) begin
            q.push_back(wd);
`ifdef AXI_WR_BURST_PAD_FLUSH_EN
            if (m_pad) begin
                if (m_pos == BL - 1) m_pad = 0;
            end else if (s_tlast && m_pos != BL - 1) begin
                m_pad = 1;
            end
`endif
            m_pos = (m_pos + 1) % BL;
        end
        m_rdy_en = 1;
        @(negedge i_clk);
    endtask

    task automatic idle(input int n);
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        repeat (n) step();
    endtask

    // Offers n beats of incrementing data, giving up after budget cycles.
    task automatic offer(input int n, input bit last_on_final, input int budget);
        int sent = 0;
        bit accepted;
        for (int cyc = 0; cyc < budget && sent < n; cyc++) begin
            s_tvalid = 1'b1;
            s_tdata  = next_data;
            s_tlast  = last_on_final && (sent == n - 1);
            accepted = s_tready;
            step();
            if (accepted) begin
                sent++;
                next_data = next_data + 64'd1;
            end
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic reset_dut();
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        i_rst_n  = 1'b0;
        #1;
        check("rst_m_tvalid", m_tvalid, 1'b0);
        check("rst_m_tlast", m_tlast, 1'b0);
        check("rst_s_tready", s_tready, 1'b0);
        check("rst_o_level", o_level, 0);
        q.delete();
        m_burst = 0; m_sent = 0; m_pos = 0; m_pad = 0; m_rdy_en = 0;
        repeat (2) @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        check("post_rst_s_tready", s_tready, 1'b1);
        clr();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{n_offer: 16, rdy_mode: 1, exp_acc: 16, exp_out: 16, exp_last: 1, exp_level: 0};
        tbl[1] = '{n_offer: 15, rdy_mode: 1, exp_acc: 15, exp_out: 0,  exp_last: 0, exp_level: 15};
        tbl[2] = '{n_offer: 32, rdy_mode: 2, exp_acc: 32, exp_out: 32, exp_last: 2, exp_level: 0};
        tbl[3] = '{n_offer: 20, rdy_mode: 1, exp_acc: 20, exp_out: 16, exp_last: 1, exp_level: 4};
        tbl[4] = '{n_offer: 48, rdy_mode: 1, exp_acc: 48, exp_out: 48, exp_last: 3, exp_level: 0};
        tbl[5] = '{n_offer: 70, rdy_mode: 0, exp_acc: 64, exp_out: 0,  exp_last: 0, exp_level: 64};

        i_rst_n  = 1'b1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tdata  = '0;
        m_tready = 1'b0;
        rdy_mode = 1;
        #2;

        for (int i = 0; i < 6; i++) begin
            reset_dut();
            rdy_mode = tbl[i].rdy_mode;
            offer(tbl[i].n_offer, 1'b0, tbl[i].n_offer + 40);
            idle(100);
            check($sformatf("vec%0d_accepted", i), acc_cnt, tbl[i].exp_acc);
            check($sformatf("vec%0d_beats_out", i), out_cnt, tbl[i].exp_out);
            check($sformatf("vec%0d_tlast_count", i), last_cnt, tbl[i].exp_last);
            check($sformatf("vec%0d_level", i), o_level, tbl[i].exp_level);
        end

        // Full buffer from the last vector drains completely once the downstream accepts again.
        check("full_s_tready", s_tready, 1'b0);
        clr();
        rdy_mode = 1;
        idle(150);
        check("drain_beats_out", out_cnt, 64);
        check("drain_tlast_count", last_cnt, 4);
        check("drain_level", o_level, 0);

        // Reset asserted seven beats into a burst, then a fresh burst afterwards.
        reset_dut();
        rdy_mode = 1;
        offer(16, 1'b0, 40);
        for (int i = 0; i < 60 && out_cnt < 7; i++) step();
        check("midburst_progress", out_cnt, 7);
        reset_dut();
        rdy_mode = 1;
        offer(16, 1'b0, 40);
        idle(40);
        check("after_rst_beats_out", out_cnt, 16);
        check("after_rst_tlast_count", last_cnt, 1);

        // Short packet terminated by s_tlast on its fifth beat.
        reset_dut();
        rdy_mode = 1;
        offer(5, 1'b1, 20);
        idle(60);
`ifdef AXI_WR_BURST_PAD_FLUSH_EN
        check("pad_beats_out", out_cnt, 16);
        check("pad_zero_beats", zero_cnt, 11);
        check("pad_tready_low", low_cnt, 11);
        check("pad_level", o_level, 0);
`else
        check("nopad_beats_out", out_cnt, 0);
        check("nopad_tready_low", low_cnt, 0);
        check("nopad_level", o_level, 5);
`endif

        // Random traffic against the model.
        reset_dut();
        rdy_mode = 3;
        for (int i = 0; i < 3000; i++) begin
            s_tvalid = 1'($urandom_range(0, 1));
            s_tdata  = {$urandom, $urandom};
            s_tlast  = ($urandom_range(0, 7) == 0);
            step();
        end
        rdy_mode = 1;
        idle(200);
        check("random_residual_level", o_level, q.size());
        check("random_no_burst_left", m_tvalid, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
